// File: rtl/udp_tx_stager_if.sv
// Upstream source and eth_tx application signals of the UDP transmit stager.
// slave is the stager's view; master is the view of whatever drives it.
interface udp_tx_stager_if #(
  parameter int DATA_W    = 16,
  parameter int KEEP_W    = DATA_W / 8,
  parameter int PKT_LEN_W = 16
);
  logic                 src_valid_i;
  logic [DATA_W-1:0]    src_data_i;
  logic [KEEP_W-1:0]    src_keep_i;
  logic                 src_last_i;
  logic                 src_cancel_i;
  logic                 src_ready_o;
  logic                 app_early_v_o;
  logic                 app_ready_v_i;
  logic                 app_valid_o;
  logic [DATA_W-1:0]    app_data_o;
  logic [KEEP_W-1:0]    app_len_o;
  logic [PKT_LEN_W-1:0] app_pkt_len_o;
  logic [15:0]          app_cs_o;
  logic                 app_cancel_o;
  logic                 err_ovf_o;

  modport slave (
    input  src_valid_i, src_data_i, src_keep_i, src_last_i, src_cancel_i, app_ready_v_i,
    output src_ready_o, app_early_v_o, app_valid_o, app_data_o, app_len_o,
           app_pkt_len_o, app_cs_o, app_cancel_o, err_ovf_o
  );

  modport master (
    output src_valid_i, src_data_i, src_keep_i, src_last_i, src_cancel_i, app_ready_v_i,
    input  src_ready_o, app_early_v_o, app_valid_o, app_data_o, app_len_o,
           app_pkt_len_o, app_cs_o, app_cancel_o, err_ovf_o
  );
endinterface

// File: rtl/udp_tx_stager.sv
// UDP transmit stager: buffers one payload packet, accumulates its byte
// length and ones'-complement checksum, then requests eth_tx and replays the
// buffered words back-to-back once granted.
//
// state | meaning
// IDLE  | waiting for first word; also swallows the tail of an overflowed packet
// FILL  | accepting payload words into the buffer
// REQ   | packet complete, app_early_v_o raised, waiting for app_ready_v_i
// SEND  | issuing one buffered word per cycle
module udp_tx_stager #(
  parameter int DATA_W    = 16,
  parameter int KEEP_W    = DATA_W / 8,
  parameter int DEPTH     = 32,
  parameter int PKT_LEN_W = 16
) (
  input  logic clk,
  input  logic reset,
  udp_tx_stager_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, FILL, REQ, SEND} state_t;

  state_t               r_state, w_state_nxt;
  logic [DATA_W-1:0]    r_mem [DEPTH];
  logic [CW-1:0]        r_wr_cnt;
  logic [AW-1:0]        r_rd_ptr;
  logic [PKT_LEN_W-1:0] r_byte_cnt;
  logic [15:0]          r_cs;
  logic [KEEP_W-1:0]    r_last_keep;
  logic                 r_drop;
  logic                 r_err_ovf;

  logic                 w_src_ready, w_accept, w_full, w_last_rd;
  logic                 w_wr_en, w_clr, w_ovf, w_set_drop, w_clr_drop, w_rd_adv;
  logic [PKT_LEN_W-1:0] w_pop;
  logic [15:0]          w_cs_word, w_cs_nxt;
  logic [16:0]          w_cs_sum;

  assign w_src_ready = !reset && (r_state == IDLE || r_state == FILL);
  assign w_accept    = bus.src_valid_i && w_src_ready;
  assign w_full      = (r_wr_cnt == CW'(DEPTH));
  assign w_last_rd   = ((CW'(r_rd_ptr) + CW'(1)) == r_wr_cnt);

  // Byte count increment and folded checksum of the incoming word; a missing
  // byte lane contributes zero, byte 0 is the high half of the summed value.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < KEEP_W; i++) w_pop = w_pop + PKT_LEN_W'(bus.src_keep_i[i]);
    w_cs_word = {bus.src_keep_i[0] ? bus.src_data_i[7:0]  : 8'h00,
                 bus.src_keep_i[1] ? bus.src_data_i[15:8] : 8'h00};
    w_cs_sum  = {1'b0, r_cs} + {1'b0, w_cs_word};
    w_cs_nxt  = w_cs_sum[15:0] + {15'b0, w_cs_sum[16]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_clr       = 1'b0;
    w_ovf       = 1'b0;
    w_set_drop  = 1'b0;
    w_clr_drop  = 1'b0;
    w_rd_adv    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (bus.src_cancel_i) begin
            w_clr      = 1'b1;
            w_clr_drop = 1'b1;
          end else if (r_drop) begin
            w_clr_drop = bus.src_last_i;
          end else begin
            w_wr_en     = 1'b1;
            w_state_nxt = bus.src_last_i ? REQ : FILL;
          end
        end
      end
      FILL: begin
        if (bus.src_cancel_i) begin
          w_clr       = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_accept) begin
          if (w_full) begin
            // Word does not fit: drop the packet, swallow the rest in IDLE.
            w_ovf       = 1'b1;
            w_clr       = 1'b1;
            w_set_drop  = !bus.src_last_i;
            w_state_nxt = IDLE;
          end else begin
            w_wr_en = 1'b1;
            if (bus.src_last_i) w_state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (bus.app_ready_v_i) w_state_nxt = SEND;
      end
      SEND: begin
        w_rd_adv = 1'b1;
        if (w_last_rd) begin
          w_clr       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pointers, length, checksum and drop/overflow flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_cnt    <= '0;
      r_rd_ptr    <= '0;
      r_byte_cnt  <= '0;
      r_cs        <= '0;
      r_last_keep <= '0;
      r_drop      <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      r_err_ovf <= w_ovf;
      if (w_clr) begin
        r_wr_cnt   <= '0;
        r_rd_ptr   <= '0;
        r_byte_cnt <= '0;
        r_cs       <= '0;
      end else begin
        if (w_wr_en) begin
          r_wr_cnt   <= r_wr_cnt + CW'(1);
          r_byte_cnt <= r_byte_cnt + w_pop;
          r_cs       <= w_cs_nxt;
          if (bus.src_last_i) r_last_keep <= bus.src_keep_i;
        end
        if (w_rd_adv) r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_set_drop)      r_drop <= 1'b1;
      else if (w_clr_drop) r_drop <= 1'b0;
    end
  end

  // Payload buffer write port.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_cnt[AW-1:0]] <= bus.src_data_i;
  end

  // Outputs, forced to their idle values while reset is high.
  always_comb begin
    bus.src_ready_o   = w_src_ready;
    bus.app_early_v_o = !reset && (r_state == REQ || r_state == SEND);
    bus.app_valid_o   = !reset && (r_state == SEND);
    bus.app_data_o    = '0;
    bus.app_len_o     = '0;
    if (bus.app_valid_o) begin
      bus.app_data_o = r_mem[r_rd_ptr];
      bus.app_len_o  = w_last_rd ? r_last_keep : '1;
    end
    bus.app_pkt_len_o = reset ? '0 : r_byte_cnt;
    bus.app_cs_o      = reset ? '0 : r_cs;
    bus.app_cancel_o  = 1'b0;
    bus.err_ovf_o     = !reset && r_err_ovf;
  end
endmodule

// File: tb/tb_udp_tx_stager.sv
// Directed bench for udp_tx_stager: packet staging, checksum, cancel,
// overflow, reset during transmit and early grant.
module tb_udp_tx_stager;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  udp_tx_stager_if bus ();
  udp_tx_stager dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int ovf_total = 0;
  int early_total = 0;
  logic [7:0] pb [0:127];

  always @(negedge clk) begin
    if (bus.err_ovf_o === 1'b1) ovf_total++;
    if (bus.app_early_v_o === 1'b1) early_total++;
  end

  function automatic logic [15:0] exp_word(input int w, input int nb);
    logic [7:0] b1;
    b1 = (2 * w + 1 < nb) ? pb[2 * w + 1] : 8'h00;
    return {b1, pb[2 * w]};
  endfunction

  task automatic idle_inputs();
    bus.src_valid_i  = 1'b0;
    bus.src_data_i   = '0;
    bus.src_keep_i   = '0;
    bus.src_last_i   = 1'b0;
    bus.src_cancel_i = 1'b0;
  endtask

  // Sends nb bytes from pb; cancel_w (1-based) marks the word carrying src_cancel_i.
  task automatic drive_pkt(input int nb, input int cancel_w);
    int nw;
    nw = (nb + 1) / 2;
    for (int w = 0; w < nw; w++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.src_ready_o !== 1'b1) begin
        n_bad++;
        $display("FAIL src_ready word %0d: got %b want 1", w, bus.src_ready_o);
      end
      bus.src_valid_i  = 1'b1;
      bus.src_data_i   = exp_word(w, nb);
      bus.src_keep_i   = (2 * w + 1 < nb) ? 2'b11 : 2'b01;
      bus.src_last_i   = (w == nw - 1);
      bus.src_cancel_i = (w + 1 == cancel_w);
      @(posedge clk);
      if (w + 1 == cancel_w) break;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic expect_tx(input string nm, input int nb, input logic [15:0] cs, input int gdelay);
    int t;
    int nw;
    logic [1:0] elen;
    nw = (nb + 1) / 2;
    t = 0;
    while (bus.app_early_v_o !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (bus.app_early_v_o !== 1'b1) begin
      n_bad++;
      $display("FAIL %s early_timeout: got %b want 1", nm, bus.app_early_v_o);
      return;
    end
    repeat (gdelay) begin
      n_cmp++;
      if (bus.app_valid_o !== 1'b0 || bus.app_early_v_o !== 1'b1) begin
        n_bad++;
        $display("FAIL %s req_wait: valid %b early %b want 0 1", nm, bus.app_valid_o, bus.app_early_v_o);
      end
      @(negedge clk);
    end
    bus.app_ready_v_i = 1'b1;
    @(negedge clk);
    bus.app_ready_v_i = 1'b0;
    for (int w = 0; w < nw; w++) begin
      elen = (w == nw - 1 && (nb % 2) == 1) ? 2'b01 : 2'b11;
      n_cmp++;
      if (bus.app_valid_o !== 1'b1 || bus.app_early_v_o !== 1'b1) begin
        n_bad++;
        $display("FAIL %s valid w%0d: valid %b early %b want 1 1", nm, w, bus.app_valid_o, bus.app_early_v_o);
      end
      n_cmp++;
      if (bus.app_data_o !== exp_word(w, nb)) begin
        n_bad++;
        $display("FAIL %s data w%0d: got %h want %h", nm, w, bus.app_data_o, exp_word(w, nb));
      end
      n_cmp++;
      if (bus.app_len_o !== elen) begin
        n_bad++;
        $display("FAIL %s len w%0d: got %b want %b", nm, w, bus.app_len_o, elen);
      end
      n_cmp++;
      if (bus.app_pkt_len_o !== 16'(nb) || bus.app_cs_o !== cs) begin
        n_bad++;
        $display("FAIL %s pktlen/cs w%0d: got %0d/%h want %0d/%h", nm, w, bus.app_pkt_len_o, bus.app_cs_o, nb, cs);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (bus.app_valid_o !== 1'b0 || bus.app_early_v_o !== 1'b0 || bus.src_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL %s end: valid %b early %b ready %b want 0 0 1", nm, bus.app_valid_o, bus.app_early_v_o, bus.src_ready_o);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    n_cmp++;
    if (bus.src_ready_o !== 1'b0 || bus.app_early_v_o !== 1'b0 || bus.app_valid_o !== 1'b0 ||
        bus.app_len_o !== 2'b00 || bus.app_data_o !== 16'h0 || bus.app_pkt_len_o !== 16'h0 ||
        bus.app_cs_o !== 16'h0 || bus.err_ovf_o !== 1'b0 || bus.app_cancel_o !== 1'b0) begin
      n_bad++;
      $display("FAIL %s outputs: rdy %b early %b val %b len %b data %h plen %h cs %h ovf %b want all 0",
               nm, bus.src_ready_o, bus.app_early_v_o, bus.app_valid_o, bus.app_len_o,
               bus.app_data_o, bus.app_pkt_len_o, bus.app_cs_o, bus.err_ovf_o);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.src_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release ready: got %b want 1", bus.src_ready_o);
    end
  endtask

  task automatic test_pkt19();
    for (int i = 0; i < 19; i++) pb[i] = 8'(i);
    drive_pkt(19, 0);
    expect_tx("pkt19", 19, 16'h5A51, 2);
  endtask

  task automatic test_checksum();
    pb[0] = 8'h00; pb[1] = 8'h01; pb[2] = 8'hF2; pb[3] = 8'h03;
    pb[4] = 8'hF4; pb[5] = 8'hF5; pb[6] = 8'hF6; pb[7] = 8'hF7;
    drive_pkt(8, 0);
    expect_tx("cksum8", 8, 16'hDDF2, 0);
  endtask

  task automatic test_cancel();
    int e0;
    for (int i = 0; i < 12; i++) pb[i] = 8'(8'hA0 + i);
    e0 = early_total;
    drive_pkt(12, 3);
    repeat (8) @(negedge clk);
    n_cmp++;
    if (early_total != e0) begin
      n_bad++;
      $display("FAIL cancel early: got %0d cycles want 0", early_total - e0);
    end
    pb[0] = 8'h12; pb[1] = 8'h34; pb[2] = 8'h56; pb[3] = 8'h78;
    drive_pkt(4, 0);
    expect_tx("after_cancel", 4, 16'h68AC, 1);
  endtask

  task automatic test_overflow(input int nb);
    int e0;
    int o0;
    for (int i = 0; i < nb; i++) pb[i] = 8'(i);
    e0 = early_total;
    o0 = ovf_total;
    drive_pkt(nb, 0);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (ovf_total - o0 != 1) begin
      n_bad++;
      $display("FAIL ovf%0d pulses: got %0d want 1", nb, ovf_total - o0);
    end
    n_cmp++;
    if (early_total != e0) begin
      n_bad++;
      $display("FAIL ovf%0d early: got %0d cycles want 0", nb, early_total - e0);
    end
    pb[0] = 8'h80; pb[1] = 8'h00; pb[2] = 8'h80; pb[3] = 8'h01;
    drive_pkt(4, 0);
    expect_tx("after_ovf", 4, 16'h0002, 1);
  endtask

  task automatic test_reset_in_send();
    int t;
    for (int i = 0; i < 10; i++) pb[i] = 8'(8'h40 + i);
    drive_pkt(10, 0);
    t = 0;
    while (bus.app_early_v_o !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    bus.app_ready_v_i = 1'b1;
    @(negedge clk);
    bus.app_ready_v_i = 1'b0;
    for (int w = 0; w < 2; w++) begin
      n_cmp++;
      if (bus.app_valid_o !== 1'b1 || bus.app_data_o !== exp_word(w, 10)) begin
        n_bad++;
        $display("FAIL rst_send w%0d: valid %b data %h want 1 %h", w, bus.app_valid_o, bus.app_data_o, exp_word(w, 10));
      end
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_send");
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.src_ready_o !== 1'b1 || bus.app_early_v_o !== 1'b0 || bus.app_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_send release: ready %b early %b valid %b want 1 0 0", bus.src_ready_o, bus.app_early_v_o, bus.app_valid_o);
    end
    pb[0] = 8'h12; pb[1] = 8'h34; pb[2] = 8'h56; pb[3] = 8'h78;
    drive_pkt(4, 0);
    expect_tx("after_rst", 4, 16'h68AC, 0);
  endtask

  task automatic test_grant_in_idle();
    bus.app_ready_v_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.src_ready_o !== 1'b1 || bus.app_early_v_o !== 1'b0) begin
      n_bad++;
      $display("FAIL gidle idle: ready %b early %b want 1 0", bus.src_ready_o, bus.app_early_v_o);
    end
    pb[0] = 8'hAB; pb[1] = 8'hCD; pb[2] = 8'hEF;
    drive_pkt(3, 0);
    n_cmp++;
    if (bus.app_early_v_o !== 1'b1 || bus.app_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL gidle req: early %b valid %b want 1 0", bus.app_early_v_o, bus.app_valid_o);
    end
    @(negedge clk);
    bus.app_ready_v_i = 1'b0;
    n_cmp++;
    if (bus.app_valid_o !== 1'b1 || bus.app_data_o !== 16'hCDAB || bus.app_len_o !== 2'b11) begin
      n_bad++;
      $display("FAIL gidle w0: valid %b data %h len %b want 1 cdab 11", bus.app_valid_o, bus.app_data_o, bus.app_len_o);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.app_valid_o !== 1'b1 || bus.app_data_o !== 16'h00EF || bus.app_len_o !== 2'b01 ||
        bus.app_pkt_len_o !== 16'd3 || bus.app_cs_o !== 16'h9ACE) begin
      n_bad++;
      $display("FAIL gidle w1: valid %b data %h len %b plen %0d cs %h want 1 00ef 01 3 9ace",
               bus.app_valid_o, bus.app_data_o, bus.app_len_o, bus.app_pkt_len_o, bus.app_cs_o);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.app_valid_o !== 1'b0 || bus.app_data_o !== 16'h0 || bus.src_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL gidle end: valid %b data %h ready %b want 0 0000 1", bus.app_valid_o, bus.app_data_o, bus.src_ready_o);
    end
  endtask

  initial begin
    idle_inputs();
    bus.app_ready_v_i = 1'b0;
    test_reset();
    test_pkt19();
    test_checksum();
    test_cancel();
    test_overflow(66);
    test_overflow(70);
    test_reset_in_send();
    test_grant_in_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
